// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default timing for the pulse stretcher and its pending queue.
package pulse_stretcher_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HIGH = ST_HIGH,
    GAP  = ST_GAP
  } state_t;

  // Defaults assume a 100 MHz clk: 10 ms high window, 5 ms low gap.
  localparam int unsigned CLK_HZ              = 100_000_000;
  localparam int unsigned DEFAULT_HIGH_CYCLES = CLK_HZ / 100;
  localparam int unsigned DEFAULT_GAP_CYCLES  = CLK_HZ / 200;
  localparam int unsigned DEFAULT_MAX_PENDING = 7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up/down counter; simultaneous inc and dec hold the count.
module sat_counter #(
  parameter  int unsigned MAX = 7,
  localparam int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam logic [W-1:0] MAX_VAL = W'(MAX);

  assign full  = (count == MAX_VAL);
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + W'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into fixed-width high windows separated by a
// guaranteed low gap, queueing strobes that arrive while a window is active.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter  int unsigned HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
  parameter  int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter  int unsigned MAX_PENDING = DEFAULT_MAX_PENDING,
  localparam int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pulse_in,
  input  logic          clear,
  output logic          level_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int unsigned     TW        = width_for(max_u(HIGH_CYCLES, GAP_CYCLES));
  localparam logic [TW-1:0]   HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]   GAP_LOAD  = TW'(GAP_CYCLES - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            level_d;
  logic            ovf_d;
  logic            q_inc, q_dec, q_clr, q_full, q_empty;

  sat_counter #(
    .MAX (MAX_PENDING)
  ) u_pending (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (q_clr),
    .inc   (q_inc),
    .dec   (q_dec),
    .count (pending),
    .full  (q_full),
    .empty (q_empty)
  );

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      level_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      level_out <= level_d;
      overflow  <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    level_d = level_out;
    ovf_d   = 1'b0;
    q_inc   = 1'b0;
    q_dec   = 1'b0;
    q_clr   = 1'b0;

    if (clear) begin
      state_d = IDLE;
      timer_d = '0;
      level_d = 1'b0;
      q_clr   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pulse_in) begin
            state_d = HIGH;
            timer_d = HIGH_LOAD;
            level_d = 1'b1;
          end
        end
        HIGH: begin
          if (timer_q == '0) begin
            state_d = GAP;
            timer_d = GAP_LOAD;
            level_d = 1'b0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
          if (pulse_in) begin
            if (q_full) ovf_d = 1'b1;
            else        q_inc = 1'b1;
          end
        end
        GAP: begin
          if (timer_q == '0) begin
            // Last gap cycle: a queued pulse and a fresh strobe both start the
            // next window; with both present the queue nets out unchanged.
            q_dec = !q_empty;
            q_inc = pulse_in && !q_empty;
            if (!q_empty || pulse_in) begin
              state_d = HIGH;
              timer_d = HIGH_LOAD;
              level_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            timer_d = timer_q - TW'(1);
            if (pulse_in) begin
              if (q_full) ovf_d = 1'b1;
              else        q_inc = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          level_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HIGH_CYCLES=4, GAP_CYCLES=2, MAX_PENDING=3.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse_in;
  logic       clear;
  logic       level_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int unsigned tests    = 0;
  int unsigned failures = 0;

  pulse_stretcher #(
    .HIGH_CYCLES (4),
    .GAP_CYCLES  (2),
    .MAX_PENDING (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .clear     (clear),
    .level_out (level_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic string rep(input string c, input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".level"},    0, 32'(level_out), 0);
    chk({tag, ".busy"},     0, 32'(busy),      0);
    chk({tag, ".pending"},  0, 32'(pending),   0);
    chk({tag, ".overflow"}, 0, 32'(overflow),  0);
  endtask

  // Row i drives pin[i]/clr[i] for one cycle, then checks the outputs of the next cycle.
  task automatic run(input string tag, input string pin, input string clr,
                     input string lvl, input string bsy, input string pnd, input string ovf);
    for (int i = 0; i < pin.len(); i++) begin
      pulse_in = (pin[i] == "1");
      clear    = (i < clr.len()) && (clr[i] == "1");
      @(posedge clk);
      #1;
      pulse_in = 1'b0;
      clear    = 1'b0;
      chk({tag, ".level"},    i, 32'(level_out), 32'(lvl[i] == "1"));
      chk({tag, ".busy"},     i, 32'(busy),      32'(bsy[i] == "1"));
      chk({tag, ".pending"},  i, 32'(pending),   32'(int'(pnd[i]) - 48));
      chk({tag, ".overflow"}, i, 32'(overflow),  32'(ovf[i] == "1"));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    clear    = 1'b0;
    #2;
    chk_all_zero("reset_async");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("reset_state");

    // Single window, then a fresh pulse in the first idle cycle.
    run("single_b2b", {"10000001", rep("0", 6)}, "",
        "11110001111000", "11111101111110", rep("0", 14), rep("0", 14));

    run("queue2", {"1011", rep("0", 16)}, "",
        "11110011110011110000", {rep("1", 18), "00"},
        "00122211111100000000", rep("0", 20));

    run("saturate", {"111111", rep("0", 19)}, "",
        "1111001111001111001111000", {rep("1", 24), "0"},
        {"0123332222221111110", rep("0", 6)}, {"000011", rep("0", 19)});

    run("deq_enq_p1", {"1010001", rep("0", 13)}, "",
        "11110011110011110000", {rep("1", 18), "00"},
        {"00", rep("1", 10), rep("0", 8)}, rep("0", 20));

    run("deq_enq_full", {"1111001", rep("0", 24)}, "",
        {"111100", "111100", "111100", "111100", "111100", "0"}, {rep("1", 30), "0"},
        {"012", rep("3", 9), rep("2", 6), rep("1", 6), rep("0", 7)}, rep("0", 31));

    run("clear", "11110000", "00010000",
        "11100000", "11100000", "01200000", rep("0", 8));

    // Async reset in the middle of the gap with two pulses queued.
    run("pre_reset", "11100", "", "11110", "11111", "01222", "00000");
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid_gap");
    @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("post_reset", {"1", rep("0", 7)}, "",
        "11110000", "11111100", rep("0", 8), rep("0", 8));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
